// File: rtl/dma_pkg.sv
// Shared definitions for the chip-bus DMA slot scheduler: owner codes,
// fixed-slot kinds, DMACON bit positions and register addresses.
package dma_pkg;

   // Slot owner codes driven onto the chip RAM address mux select.
   typedef enum logic [2:0] {
      OWN_CPU      = 3'd0,
      OWN_REFRESH  = 3'd1,
      OWN_DISK     = 3'd2,
      OWN_AUDIO    = 3'd3,
      OWN_SPRITE   = 3'd4,
      OWN_BITPLANE = 3'd5,
      OWN_COPPER   = 3'd6,
      OWN_BLITTER  = 3'd7
   } owner_e;

   // Kind of fixed slot found at a given slot index.
   typedef enum logic [2:0] {
      FK_NONE    = 3'd0,
      FK_REFRESH = 3'd1,
      FK_DISK    = 3'd2,
      FK_AUDIO   = 3'd3,
      FK_SPRITE  = 3'd4
   } fixed_kind_e;

   // DMACON bit positions (audio channels occupy bits 3:0).
   localparam logic [3:0] DC_BLTPRI = 4'd10;
   localparam logic [3:0] DC_DMAEN  = 4'd9;
   localparam logic [3:0] DC_BPLEN  = 4'd8;
   localparam logic [3:0] DC_COPEN  = 4'd7;
   localparam logic [3:0] DC_BLTEN  = 4'd6;
   localparam logic [3:0] DC_SPREN  = 4'd5;
   localparam logic [3:0] DC_DSKEN  = 4'd4;

   // Full byte addresses of the control/status registers.
   localparam logic [8:0] DMACON_ADDR  = 9'h096;
   localparam logic [8:0] DMACONR_ADDR = 9'h002;

   // Slots at or beyond this index never carry fixed DMA.
   localparam logic [7:0] SLOT_WRAP = 8'hE3;

   // An enable only counts when the master DMA enable is also set.
   function automatic logic dma_on(input logic [10:0] dmacon, input logic [3:0] idx);
      return dmacon[DC_DMAEN] & dmacon[idx];
   endfunction

endpackage

// File: rtl/dma_slot_decode.sv
// Combinational slot-index decoder: maps slot S to the fixed DMA kind
// reserved there (if any) and the audio/sprite channel number.
module dma_slot_decode
   import dma_pkg::*;
#(
   parameter logic [7:0] REFRESH_FIRST = 8'h01,
   parameter logic [7:0] DISK_FIRST    = 8'h09,
   parameter logic [7:0] AUDIO_FIRST   = 8'h0F,
   parameter logic [7:0] SPRITE_FIRST  = 8'h17
) (
   input  logic [7:0]  slot,
   output fixed_kind_e fixed_kind,
   output logic [2:0]  channel
);

   logic [3:0] ref_hit;
   logic [2:0] dsk_hit;
   logic [3:0] aud_hit;
   logic [7:0] spr_hit;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_ref
         assign ref_hit[gi] = (slot == REFRESH_FIRST + 8'(2 * gi));
      end
      for (gi = 0; gi < 3; gi++) begin : g_dsk
         assign dsk_hit[gi] = (slot == DISK_FIRST + 8'(2 * gi));
      end
      for (gi = 0; gi < 4; gi++) begin : g_aud
         assign aud_hit[gi] = (slot == AUDIO_FIRST + 8'(2 * gi));
      end
      for (gi = 0; gi < 8; gi++) begin : g_spr
         assign spr_hit[gi] = (slot == SPRITE_FIRST + 8'(4 * gi)) ||
                              (slot == SPRITE_FIRST + 8'(4 * gi + 2));
      end
   endgenerate

   // Priority-encode the hit vectors; slots past the wrap point are always variable.
   always_comb begin
      fixed_kind = FK_NONE;
      channel    = 3'd0;
      if (slot < SLOT_WRAP) begin
         if (|ref_hit) begin
            fixed_kind = FK_REFRESH;
         end else if (|dsk_hit) begin
            fixed_kind = FK_DISK;
         end else if (|aud_hit) begin
            fixed_kind = FK_AUDIO;
            for (int i = 0; i < 4; i++) begin
               if (aud_hit[i]) channel = 3'(i);
            end
         end else if (|spr_hit) begin
            fixed_kind = FK_SPRITE;
            for (int i = 0; i < 8; i++) begin
               if (spr_hit[i]) channel = 3'(i);
            end
         end
      end
   end

endmodule

// File: rtl/dma_slot_scheduler.sv
// Chip-bus DMA slot arbiter. Holds DMACON and, on every clk edge with
// cck=1, registers the owner of the current slot (1 clk latency).
// Optional feature macro: BLT_STARVE_GUARD_EN -- when defined, a blitter
// starvation guard hands every third CPU-blocking blitter slot to the CPU
// unless BLTPRI is set.
module dma_slot_scheduler
   import dma_pkg::*;
#(
   parameter logic [7:0] REFRESH_FIRST = 8'h01,
   parameter logic [7:0] DISK_FIRST    = 8'h09,
   parameter logic [7:0] AUDIO_FIRST   = 8'h0F,
   parameter logic [7:0] SPRITE_FIRST  = 8'h17,
   parameter int         STARVE_LIMIT  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cck,
   input  logic [8:0]  hpos,
   input  logic        vbl,
   input  logic        vblend,
   input  logic [7:0]  reg_address_in,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   input  logic        bbusy,
   input  logic        dsk_req,
   input  logic [3:0]  aud_req,
   input  logic        bpl_req,
   input  logic        cop_req,
   input  logic        blt_req,
   input  logic        cpu_req,
   output logic [2:0]  owner,
   output logic [1:0]  aud_sel,
   output logic [2:0]  spr_sel,
   output logic        cpu_wait
);

   localparam logic [7:0] DMACON_REG  = DMACON_ADDR[8:1];
   localparam logic [7:0] DMACONR_REG = DMACONR_ADDR[8:1];

   logic [7:0]  slot;
   fixed_kind_e fixed_kind;
   logic [2:0]  channel;
   logic [10:0] dmacon_reg;
   logic        dmacon_wr;
   owner_e      owner_reg, owner_next;
   logic [1:0]  aud_sel_reg, aud_sel_next;
   logic [2:0]  spr_sel_reg, spr_sel_next;
   logic        fixed_hit;
   logic        starve_block;
   logic [4:0]  inputs_unused;

   // hpos[0] selects the clk within a colour clock and data_in[14:11] are unused.
   assign inputs_unused = {hpos[0], data_in[14:11]};
   assign slot          = hpos[8:1];
   assign dmacon_wr     = (reg_address_in == DMACON_REG);

   dma_slot_decode #(
      .REFRESH_FIRST (REFRESH_FIRST),
      .DISK_FIRST    (DISK_FIRST),
      .AUDIO_FIRST   (AUDIO_FIRST),
      .SPRITE_FIRST  (SPRITE_FIRST)
   ) u_decode (
      .slot       (slot),
      .fixed_kind (fixed_kind),
      .channel    (channel)
   );

   // DMACON set/clear register; a write lands after the decision on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         dmacon_reg <= 11'd0;
      end else if (dmacon_wr) begin
         if (data_in[15]) dmacon_reg <= dmacon_reg | data_in[10:0];
         else             dmacon_reg <= dmacon_reg & ~data_in[10:0];
      end
   end

   // Slot decision: fixed slot if used, otherwise bitplane > copper > blitter > CPU.
   always_comb begin
      owner_next   = OWN_CPU;
      aud_sel_next = aud_sel_reg;
      spr_sel_next = spr_sel_reg;
      fixed_hit    = 1'b0;
      case (fixed_kind)
         FK_REFRESH: begin
            owner_next = OWN_REFRESH;
            fixed_hit  = 1'b1;
         end
         FK_DISK: begin
            if (dsk_req && dma_on(dmacon_reg, DC_DSKEN)) begin
               owner_next = OWN_DISK;
               fixed_hit  = 1'b1;
            end
         end
         FK_AUDIO: begin
            if (aud_req[channel[1:0]] && dma_on(dmacon_reg, {2'b00, channel[1:0]})) begin
               owner_next   = OWN_AUDIO;
               aud_sel_next = channel[1:0];
               fixed_hit    = 1'b1;
            end
         end
         FK_SPRITE: begin
            if (dma_on(dmacon_reg, DC_SPREN) && (!vbl || vblend) && !bpl_req) begin
               owner_next   = OWN_SPRITE;
               spr_sel_next = channel;
               fixed_hit    = 1'b1;
            end
         end
         default: ;
      endcase
      if (!fixed_hit) begin
         if (bpl_req && dma_on(dmacon_reg, DC_BPLEN)) begin
            owner_next = OWN_BITPLANE;
         end else if (!slot[0] && cop_req && dma_on(dmacon_reg, DC_COPEN)) begin
            owner_next = OWN_COPPER;
         end else if (blt_req && dma_on(dmacon_reg, DC_BLTEN)) begin
            owner_next = starve_block ? OWN_CPU : OWN_BLITTER;
         end
      end
   end

   // Register the decision only on colour-clock edges; hold in between.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_reg   <= OWN_CPU;
         aud_sel_reg <= 2'd0;
         spr_sel_reg <= 3'd0;
      end else if (cck) begin
         owner_reg   <= owner_next;
         aud_sel_reg <= aud_sel_next;
         spr_sel_reg <= spr_sel_next;
      end
   end

`ifdef BLT_STARVE_GUARD_EN
   logic [1:0] starve_cnt_reg, starve_cnt_next;

   assign starve_block = (starve_cnt_reg == 2'(STARVE_LIMIT));

   // Count blitter grants that stall a waiting CPU; any CPU grant or idle CPU resets it.
   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (!cpu_req || owner_next == OWN_CPU) begin
         starve_cnt_next = 2'd0;
      end else if (owner_next == OWN_BLITTER && !dmacon_reg[DC_BLTPRI]) begin
         starve_cnt_next = starve_cnt_reg + 2'd1;
      end
   end

   // Starvation counter advances with the slot decision.
   always_ff @(posedge clk) begin
      if (reset)    starve_cnt_reg <= 2'd0;
      else if (cck) starve_cnt_reg <= starve_cnt_next;
   end
`else
   logic [1:0] starve_limit_unused;

   // Without the guard the blitter always beats the CPU and BLTPRI is storage only.
   assign starve_block        = 1'b0;
   assign starve_limit_unused = 2'(STARVE_LIMIT);
`endif

   assign owner    = owner_reg;
   assign aud_sel  = aud_sel_reg;
   assign spr_sel  = spr_sel_reg;
   assign cpu_wait = cpu_req && (owner_reg != OWN_CPU);
   assign data_out = (reg_address_in == DMACONR_REG) ?
                     {1'b0, bbusy, 3'b000, dmacon_reg} : 16'h0000;

endmodule
